// File: rtl/fetch_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue_pkg
// Shared constants and types for the instruction prefetch stage.
//   INSTR_W          : instruction word width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_INCR          : sequential fetch stride in bytes
//   NOP_INSTR        : instruction value presented while the queue is empty
//   fetch_entry_t    : one queue entry, instruction word plus its PC+4
//   word_align()     : clears the byte-offset bits of a fetch address
// -----------------------------------------------------------------------------
package fetch_prefetch_queue_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'h0000_0004;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } fetch_entry_t;

    // Instruction fetches are always word aligned; low address bits are dropped
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO of fetch_entry_t with flush.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at tail (ignored when full without a pop)
//   push_data   : entry to enqueue
//   pop         : remove head entry (ignored when empty)
//   flush       : empty the queue; wins over push and pop in the same cycle
//   head_data   : head entry, NOP/zero while empty
//   count       : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pop needs data; push needs room unless a pop frees a slot this cycle
    always_comb begin
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Pointer and occupancy state; flush returns the queue to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head presentation: stored entry when occupied, NOP with zero PC+4 otherwise
    always_comb begin
        if (count_r != {CNT_W{1'b0}}) begin
            head_data = mem_r[rd_ptr_r];
        end else begin
            head_data.instr = NOP_INSTR;
            head_data.pc4   = 32'h0000_0000;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
// Instruction prefetch stage between a request/response instruction memory and
// the IF/ID register. Issues sequential word fetches while credit allows,
// queues returned words with their PC+4, and flushes on redirects while
// discarding responses still in flight.
//   clk, reset            : clock, asynchronous active-low reset
//   redirect_valid/_pc    : taken branch/jump; flush and refetch from redirect_pc
//   imem_req/_addr        : fetch request and word-aligned address
//   imem_ready            : memory accepts request this cycle
//   imem_rvalid/_rdata    : in-order response and instruction word
//   out_valid/_instr/_pc4 : queue head presented to IF/ID
//   out_ready             : IF/ID write enable, pops the head
//   proto_err             : sticky, response seen with nothing outstanding
// -----------------------------------------------------------------------------
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc4,
    input  logic               out_ready,
    output logic               proto_err
);

    localparam int               CNT_W        = $clog2(DEPTH + 1);
    localparam int               CRD_W        = CNT_W + 1;
    localparam logic [CRD_W-1:0] CREDIT_LIMIT = CRD_W'(DEPTH);

    logic [31:0]      fetch_pc_r;
    logic [31:0]      resp_pc_r;
    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] discard_r;
    logic             proto_err_r;
    logic             active_r;

    logic [31:0]      fetch_pc_nxt_s;
    logic [31:0]      resp_pc_nxt_s;
    logic [CNT_W-1:0] outstanding_nxt_s;
    logic [CNT_W-1:0] discard_nxt_s;

    logic [CNT_W-1:0] fifo_count_s;
    logic [CRD_W-1:0] credit_sum_s;
    logic             accept_s;
    logic             rsp_s;
    logic             stray_rsp_s;
    logic             push_s;
    logic             pop_s;
    fetch_entry_t     push_data_s;
    fetch_entry_t     head_s;

    // Issue/response/pop qualification; credit uses registered occupancy only,
    // so out_ready never reaches imem_req combinationally
    always_comb begin
        credit_sum_s = CRD_W'(fifo_count_s) + CRD_W'(outstanding_r);
        imem_req     = active_r && !redirect_valid && (credit_sum_s < CREDIT_LIMIT);
        accept_s     = imem_req && imem_ready;
        rsp_s        = imem_rvalid && (outstanding_r != {CNT_W{1'b0}});
        stray_rsp_s  = imem_rvalid && (outstanding_r == {CNT_W{1'b0}});
        push_s       = rsp_s && (discard_r == {CNT_W{1'b0}}) && !redirect_valid;
        pop_s        = out_valid && out_ready && !redirect_valid;
        push_data_s.instr = imem_rdata;
        push_data_s.pc4   = resp_pc_r + PC_INCR;
    end

    // Next PCs and credit counters; a redirect marks every response not
    // arriving this very cycle as stale
    always_comb begin
        fetch_pc_nxt_s    = fetch_pc_r;
        resp_pc_nxt_s     = resp_pc_r;
        outstanding_nxt_s = outstanding_r;
        discard_nxt_s     = discard_r;
        case ({accept_s, rsp_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CNT_W'(1);
            2'b01:   outstanding_nxt_s = outstanding_r - CNT_W'(1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
        if (redirect_valid) begin
            fetch_pc_nxt_s = word_align(redirect_pc);
            resp_pc_nxt_s  = word_align(redirect_pc);
            if (rsp_s) begin
                discard_nxt_s = outstanding_r - CNT_W'(1);
            end else begin
                discard_nxt_s = outstanding_r;
            end
        end else begin
            if (accept_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_INCR;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_nxt_s = resp_pc_r + PC_INCR;
            end else begin
                resp_pc_nxt_s = resp_pc_r;
            end
            if (rsp_s && (discard_r != {CNT_W{1'b0}})) begin
                discard_nxt_s = discard_r - CNT_W'(1);
            end else begin
                discard_nxt_s = discard_r;
            end
        end
    end

    // State registers; active_r holds off the first request until the first
    // clock edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_r    <= word_align(RESET_PC);
            resp_pc_r     <= word_align(RESET_PC);
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
            proto_err_r   <= 1'b0;
            active_r      <= 1'b0;
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            resp_pc_r     <= resp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
            active_r      <= 1'b1;
            if (stray_rsp_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head_data (head_s),
        .count     (fifo_count_s)
    );

    assign imem_addr = fetch_pc_r;
    assign out_valid = (fifo_count_s != {CNT_W{1'b0}});
    assign out_instr = head_s.instr;
    assign out_pc4   = head_s.pc4;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_queue
// Drives fetch_prefetch_queue with an in-order memory model of variable
// latency and compares every cycle against a queue-based reference: in-flight
// requests carry their address and a stale flag, the output queue holds
// {word, addr+4} of non-stale responses.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        out_ready;
    logic        proto_err;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4),
        .out_ready      (out_ready),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] next_pc;
    bit          proto_exp;
    bit          model_active;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          checks;
    int          failures;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_imem_req"}, imem_req, 1'b0);
        chk32({tag, "_imem_addr"}, imem_addr, RESET_PC);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk32({tag, "_out_instr"}, out_instr, 32'h0000_0000);
        chk32({tag, "_out_pc4"}, out_pc4, 32'h0000_0000);
        chk1({tag, "_proto_err"}, proto_err, 1'b0);
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        next_pc      = RESET_PC;
        proto_exp    = 1'b0;
        model_active = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check 1ns later, advance model, wait posedge
    task automatic step(input bit rdr, input logic [31:0] rpc, input bit ord,
                        input bit mrdy, input bit bogus);
        bit          rv;
        bit          bogus_now;
        bit          exp_req;
        logic [63:0] head;
        req_t        r;
        @(negedge clk);
        rv        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bogus_now = bogus && (mem_q.size() == 0);
        redirect_valid = rdr;
        redirect_pc    = rpc;
        out_ready      = ord;
        imem_ready     = mrdy;
        imem_rvalid    = rv || bogus_now;
        imem_rdata     = rv ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        exp_req = model_active && !rdr && ((exp_q.size() + mem_q.size()) < DEPTH);
        chk1("imem_req", imem_req, exp_req);
        if (exp_req) chk32("imem_addr", imem_addr, next_pc);
        chk1("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk32("out_instr", out_instr, head[63:32]);
            chk32("out_pc4", out_pc4, head[31:0]);
        end
        chk1("proto_err", proto_err, proto_exp);
        if (bogus_now) proto_exp = 1'b1;
        if ((exp_q.size() != 0) && ord && !rdr) void'(exp_q.pop_front());
        if (rv) begin
            r = mem_q.pop_front();
            if (!rdr && !r.stale) exp_q.push_back({mem_word(r.addr), r.addr + 32'd4});
        end
        if (rdr) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            next_pc = rpc & 32'hFFFF_FFFC;
        end
        if (exp_req && mrdy) begin
            mem_q.push_back('{addr: next_pc,
                              due: cyc + int'($urandom_range(lat_max, lat_min)),
                              stale: 1'b0});
            next_pc = next_pc + 32'd4;
        end
        model_active = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        bit reached;
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
        model_reset();
        lat_min = 1; lat_max = 1;
        #2;
        check_reset_outputs("por");
        @(posedge clk); #1 reset = 1'b1;

        // Backpressure from reset: exactly DEPTH fetches, then stall
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        chk1("bp_req_low", imem_req, 1'b0);
        chk32("bp_next_addr", imem_addr, 32'h0000_0010);
        chk32("bp_head_pc4", out_pc4, 32'h0000_0004);
        chk32("bp_head_instr", out_instr, mem_word(32'h0));

        // Release: in-order drain, then steady one-per-cycle streaming
        repeat (24) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // 3-cycle latency with three in flight, then redirect to 0x100
        lat_min = 3; lat_max = 3;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (mem_q.size() == 3) reached = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        chk1("lat3_three_inflight", reached, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (exp_q.size() != 0) reached = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        chk1("redir_refill", reached, 1'b1);
        #1;
        chk32("redir_first_pc4", out_pc4, 32'h0000_0104);
        chk32("redir_first_instr", out_instr, mem_word(32'h0000_0100));
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Redirect coinciding with a response and a pop; unaligned target
        lat_min = 1; lat_max = 1;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if ((mem_q.size() > 0) && (mem_q[0].due <= cyc) && (exp_q.size() != 0)) reached = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        chk1("redir_rsp_pop_setup", reached, 1'b1);
        step(1'b1, 32'h0000_0243, 1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Push and pop together with three entries queued
        lat_min = 2; lat_max = 2;
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            if ((exp_q.size() == 3) && (mem_q.size() > 0) && (mem_q[0].due <= cyc) && !mem_q[0].stale)
                reached = 1'b1;
            else step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        end
        chk1("full3_pushpop_setup", reached, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Stray response with nothing outstanding sets the sticky error
        lat_min = 1; lat_max = 1;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (mem_q.size() == 0) reached = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk1("drain_inflight", reached, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        #1;
        chk1("proto_sticky", proto_err, 1'b1);

        // Randomized traffic: latency, readiness, drain and redirects
        lat_min = 1; lat_max = 4;
        repeat (800)
            step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 1'b0);

        // Asynchronous reset mid-stream, between clock edges
        #3;
        reset = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        lat_min = 1; lat_max = 1;
        repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
